// File: rtl/reg_file_sb.sv
// Register file with a per-register reservation scoreboard: dispatch reserves a
// destination with a producer tag, and only the matching writeback retires it.
module reg_file_sb #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra0_i,
  input  logic [AW-1:0]    ra1_i,
  output logic [WIDTH-1:0] rd0_o,
  output logic [WIDTH-1:0] rd1_o,
  output logic             rr0_o,
  output logic             rr1_o,
  input  logic             w_reserve_i,
  input  logic [AW-1:0]    w_reserve_addr_i,
  input  logic [TAGW-1:0]  w_reserve_tag_i,
  input  logic             wb_i,
  input  logic [AW-1:0]    wb_addr_i,
  input  logic [TAGW-1:0]  wb_tag_i,
  input  logic [WIDTH-1:0] wb_data_i,
  input  logic             flush_i,
  output logic [AW:0]      busy_cnt_o
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [TAGW-1:0]  tag_q  [DEPTH];
  logic [DEPTH-1:0] rsv_q;
  logic [AW:0]      busy_q;

  logic rsv_v;
  logic wb_acc;
  logic cnt_inc;
  logic cnt_dec;

  always_comb begin
    rsv_v   = w_reserve_i && (w_reserve_addr_i != '0) && !flush_i;
    wb_acc  = wb_i && (wb_addr_i != '0) && rsv_q[wb_addr_i]
              && (tag_q[wb_addr_i] == wb_tag_i);
    // A reserve that lands on the register being retired keeps it busy, so
    // neither the increment nor the decrement applies in that case.
    cnt_inc = rsv_v && !rsv_q[w_reserve_addr_i];
    cnt_dec = wb_acc && !(rsv_v && (w_reserve_addr_i == wb_addr_i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      rsv_q  <= '0;
      busy_q <= '0;
    end else begin
      if (wb_acc) data_q[wb_addr_i] <= wb_data_i;
      if (flush_i) begin
        rsv_q  <= '0;
        busy_q <= '0;
      end else begin
        if (wb_acc) rsv_q[wb_addr_i] <= 1'b0;
        // Issued after the writeback clear so a coincident reserve wins.
        if (rsv_v) begin
          rsv_q[w_reserve_addr_i] <= 1'b1;
          tag_q[w_reserve_addr_i] <= w_reserve_tag_i;
        end
        busy_q <= busy_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
      end
    end
  end

  always_comb begin
    rd0_o = data_q[ra0_i];
    rr0_o = rsv_q[ra0_i];
    if (ra0_i == '0) begin
      rd0_o = '0;
      rr0_o = 1'b0;
    end else if (wb_acc && (wb_addr_i == ra0_i)) begin
      rd0_o = wb_data_i;
      rr0_o = 1'b0;
    end

    rd1_o = data_q[ra1_i];
    rr1_o = rsv_q[ra1_i];
    if (ra1_i == '0) begin
      rd1_o = '0;
      rr1_o = 1'b0;
    end else if (wb_acc && (wb_addr_i == ra1_i)) begin
      rd1_o = wb_data_i;
      rr1_o = 1'b0;
    end
  end

  assign busy_cnt_o = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reservation, tagged writeback, bypass, flush, r0.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  ra0_i = '0, ra1_i = '0;
  logic [31:0] rd0_o, rd1_o;
  logic        rr0_o, rr1_o;
  logic        w_reserve_i = 1'b0;
  logic [4:0]  w_reserve_addr_i = '0;
  logic [3:0]  w_reserve_tag_i = '0;
  logic        wb_i = 1'b0;
  logic [4:0]  wb_addr_i = '0;
  logic [3:0]  wb_tag_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        flush_i = 1'b0;
  logic [5:0]  busy_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  reg_file_sb #(.WIDTH(32), .DEPTH(32), .AW(5), .TAGW(4)) dut (
    .clk(clk), .rst(rst),
    .ra0_i(ra0_i), .ra1_i(ra1_i),
    .rd0_o(rd0_o), .rd1_o(rd1_o), .rr0_o(rr0_o), .rr1_o(rr1_o),
    .w_reserve_i(w_reserve_i), .w_reserve_addr_i(w_reserve_addr_i),
    .w_reserve_tag_i(w_reserve_tag_i),
    .wb_i(wb_i), .wb_addr_i(wb_addr_i), .wb_tag_i(wb_tag_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i), .busy_cnt_o(busy_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    w_reserve_i = 1'b0;
    wb_i = 1'b0;
    flush_i = 1'b0;
    rst = 1'b0;
  endtask

  task automatic reserve(input logic [4:0] a, input logic [3:0] t);
    w_reserve_i = 1'b1; w_reserve_addr_i = a; w_reserve_tag_i = t;
  endtask

  task automatic wback(input logic [4:0] a, input logic [3:0] t, input logic [31:0] d);
    wb_i = 1'b1; wb_addr_i = a; wb_tag_i = t; wb_data_i = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    ra0_i = 5'd5; ra1_i = 5'd0; #1;
    n_cmp++; if (rd0_o !== 32'h0) begin n_bad++; $display("FAIL reset_rd0 got %h want 0", rd0_o); end
    n_cmp++; if (rr0_o !== 1'b0) begin n_bad++; $display("FAIL reset_rr0 got %b want 0", rr0_o); end
    n_cmp++; if (rd1_o !== 32'h0) begin n_bad++; $display("FAIL reset_rd1 got %h want 0", rd1_o); end
    n_cmp++; if (rr1_o !== 1'b0) begin n_bad++; $display("FAIL reset_rr1 got %b want 0", rr1_o); end
    n_cmp++; if (busy_cnt_o !== 6'd0) begin n_bad++; $display("FAIL reset_busy got %0d want 0", busy_cnt_o); end
  endtask

  task automatic test_reserve_wb();
    reserve(5'd3, 4'd2);
    tick();
    ra0_i = 5'd3; #1;
    n_cmp++; if (rr0_o !== 1'b1) begin n_bad++; $display("FAIL rsv_rr0 got %b want 1", rr0_o); end
    n_cmp++; if (busy_cnt_o !== 6'd1) begin n_bad++; $display("FAIL rsv_busy got %0d want 1", busy_cnt_o); end
    wback(5'd3, 4'd2, 32'hDEADBEEF); #1;
    n_cmp++; if (rd0_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bypass_rd0 got %h want deadbeef", rd0_o); end
    n_cmp++; if (rr0_o !== 1'b0) begin n_bad++; $display("FAIL bypass_rr0 got %b want 0", rr0_o); end
    tick(); #1;
    n_cmp++; if (rd0_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL stored_rd0 got %h want deadbeef", rd0_o); end
    n_cmp++; if (rr0_o !== 1'b0) begin n_bad++; $display("FAIL stored_rr0 got %b want 0", rr0_o); end
    n_cmp++; if (busy_cnt_o !== 6'd0) begin n_bad++; $display("FAIL wb_busy got %0d want 0", busy_cnt_o); end
  endtask

  task automatic test_waw();
    ra1_i = 5'd7;
    reserve(5'd7, 4'd1);
    tick();
    reserve(5'd7, 4'd4);
    tick(); #1;
    n_cmp++; if (busy_cnt_o !== 6'd1) begin n_bad++; $display("FAIL waw_busy got %0d want 1", busy_cnt_o); end
    wback(5'd7, 4'd1, 32'h11); #1;
    n_cmp++; if (rd1_o !== 32'h0 || rr1_o !== 1'b1) begin n_bad++; $display("FAIL stale_bypass got %h/%b want 0/1", rd1_o, rr1_o); end
    tick(); #1;
    n_cmp++; if (rd1_o !== 32'h0 || rr1_o !== 1'b1) begin n_bad++; $display("FAIL stale_drop got %h/%b want 0/1", rd1_o, rr1_o); end
    wback(5'd7, 4'd4, 32'h44);
    tick(); #1;
    n_cmp++; if (rd1_o !== 32'h44 || rr1_o !== 1'b0) begin n_bad++; $display("FAIL waw_wb got %h/%b want 44/0", rd1_o, rr1_o); end
    n_cmp++; if (busy_cnt_o !== 6'd0) begin n_bad++; $display("FAIL waw_busy_end got %0d want 0", busy_cnt_o); end
  endtask

  task automatic test_wb_rsv_same();
    ra0_i = 5'd9;
    reserve(5'd9, 4'd3);
    tick();
    wback(5'd9, 4'd3, 32'h99); reserve(5'd9, 4'd5); #1;
    n_cmp++; if (rd0_o !== 32'h99 || rr0_o !== 1'b0) begin n_bad++; $display("FAIL same_bypass got %h/%b want 99/0", rd0_o, rr0_o); end
    tick(); #1;
    n_cmp++; if (rd0_o !== 32'h99 || rr0_o !== 1'b1) begin n_bad++; $display("FAIL same_state got %h/%b want 99/1", rd0_o, rr0_o); end
    n_cmp++; if (busy_cnt_o !== 6'd1) begin n_bad++; $display("FAIL same_busy got %0d want 1", busy_cnt_o); end
    wback(5'd9, 4'd3, 32'h12);
    tick(); #1;
    n_cmp++; if (rd0_o !== 32'h99 || rr0_o !== 1'b1) begin n_bad++; $display("FAIL old_tag_drop got %h/%b want 99/1", rd0_o, rr0_o); end
    wback(5'd9, 4'd5, 32'h55);
    tick(); #1;
    n_cmp++; if (rd0_o !== 32'h55 || rr0_o !== 1'b0) begin n_bad++; $display("FAIL new_tag_wb got %h/%b want 55/0", rd0_o, rr0_o); end
    n_cmp++; if (busy_cnt_o !== 6'd0) begin n_bad++; $display("FAIL same_busy_end got %0d want 0", busy_cnt_o); end
  endtask

  task automatic test_flush();
    reserve(5'd1, 4'd1); tick();
    reserve(5'd2, 4'd2); tick();
    reserve(5'd4, 4'd3); tick();
    ra0_i = 5'd1; ra1_i = 5'd4; #1;
    n_cmp++; if (busy_cnt_o !== 6'd3) begin n_bad++; $display("FAIL pre_flush_busy got %0d want 3", busy_cnt_o); end
    n_cmp++; if (rr0_o !== 1'b1 || rr1_o !== 1'b1) begin n_bad++; $display("FAIL pre_flush_rr got %b%b want 11", rr0_o, rr1_o); end
    flush_i = 1'b1; reserve(5'd6, 4'd7);
    tick(); #1;
    n_cmp++; if (rr0_o !== 1'b0 || rr1_o !== 1'b0) begin n_bad++; $display("FAIL flush_rr14 got %b%b want 00", rr0_o, rr1_o); end
    ra0_i = 5'd2; ra1_i = 5'd6; #1;
    n_cmp++; if (rr0_o !== 1'b0 || rr1_o !== 1'b0) begin n_bad++; $display("FAIL flush_rr26 got %b%b want 00", rr0_o, rr1_o); end
    n_cmp++; if (busy_cnt_o !== 6'd0) begin n_bad++; $display("FAIL flush_busy got %0d want 0", busy_cnt_o); end
    reserve(5'd2, 4'd6); tick();
    flush_i = 1'b1; wback(5'd2, 4'd6, 32'h22);
    tick(); #1;
    n_cmp++; if (rd0_o !== 32'h22 || rr0_o !== 1'b0) begin n_bad++; $display("FAIL flush_wb got %h/%b want 22/0", rd0_o, rr0_o); end
    n_cmp++; if (busy_cnt_o !== 6'd0) begin n_bad++; $display("FAIL flush_wb_busy got %0d want 0", busy_cnt_o); end
  endtask

  task automatic test_r0();
    wback(5'd0, 4'd0, 32'h5); reserve(5'd0, 4'd1);
    tick();
    ra0_i = 5'd0; #1;
    n_cmp++; if (rd0_o !== 32'h0 || rr0_o !== 1'b0) begin n_bad++; $display("FAIL r0 got %h/%b want 0/0", rd0_o, rr0_o); end
    n_cmp++; if (busy_cnt_o !== 6'd0) begin n_bad++; $display("FAIL r0_busy got %0d want 0", busy_cnt_o); end
  endtask

  task automatic test_back_to_back();
    reserve(5'd10, 4'd1); tick();
    reserve(5'd11, 4'd2); wback(5'd10, 4'd1, 32'hA0);
    tick();
    ra0_i = 5'd10; ra1_i = 5'd11; #1;
    n_cmp++; if (rd0_o !== 32'hA0 || rr0_o !== 1'b0) begin n_bad++; $display("FAIL b2b_r10 got %h/%b want a0/0", rd0_o, rr0_o); end
    n_cmp++; if (rr1_o !== 1'b1) begin n_bad++; $display("FAIL b2b_r11 got %b want 1", rr1_o); end
    n_cmp++; if (busy_cnt_o !== 6'd1) begin n_bad++; $display("FAIL b2b_busy got %0d want 1", busy_cnt_o); end
  endtask

  task automatic test_mid_reset();
    reserve(5'd3, 4'd7); tick(); #1;
    n_cmp++; if (busy_cnt_o !== 6'd2) begin n_bad++; $display("FAIL pre_rst_busy got %0d want 2", busy_cnt_o); end
    rst = 1'b1; wback(5'd11, 4'd2, 32'hBB); reserve(5'd12, 4'd3);
    tick();
    ra0_i = 5'd3; ra1_i = 5'd11; #1;
    n_cmp++; if (rd0_o !== 32'h0 || rr0_o !== 1'b0) begin n_bad++; $display("FAIL rst_r3 got %h/%b want 0/0", rd0_o, rr0_o); end
    n_cmp++; if (rd1_o !== 32'h0 || rr1_o !== 1'b0) begin n_bad++; $display("FAIL rst_r11 got %h/%b want 0/0", rd1_o, rr1_o); end
    ra0_i = 5'd10; ra1_i = 5'd12; #1;
    n_cmp++; if (rd0_o !== 32'h0 || rr1_o !== 1'b0) begin n_bad++; $display("FAIL rst_r10_r12 got %h/%b want 0/0", rd0_o, rr1_o); end
    n_cmp++; if (busy_cnt_o !== 6'd0) begin n_bad++; $display("FAIL rst_busy got %0d want 0", busy_cnt_o); end
  endtask

  initial begin
    #2;
    test_reset();
    test_reserve_wb();
    test_waw();
    test_wb_rsv_same();
    test_flush();
    test_r0();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
